// File: rtl/fpu_cmd_scheduler.sv
// Queued FPU command front end: command FIFO -> one-at-a-time issue -> tagged result FIFO.
// Define FPU_SCHED_TIMEOUT_EN to add a WAIT watchdog and the FIFO-carried rsp_timeout flag.
module fpu_cmd_scheduler #(
  parameter int WIDTH     = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_opsel,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_frm,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIDTH-1:0] cmd_c,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [10:0]      fu_valid,
  output logic [1:0]       fu_op,
  output logic [2:0]       fu_frm,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  output logic [WIDTH-1:0] fu_c,
  input  logic [WIDTH-1:0] fu_result,
  input  logic [4:0]       fu_exc,
  input  logic             fu_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [4:0]       rsp_exc,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
`ifdef FPU_SCHED_TIMEOUT_EN
  output logic             rsp_timeout,
`endif
  output logic [4:0]       exc_sticky,
  input  logic             exc_clr,
  output logic             busy
);
  localparam int CA = $clog2(CMD_DEPTH);
  localparam int RA = $clog2(RSP_DEPTH);

  typedef struct packed {
    logic [3:0]       opsel;
    logic [1:0]       op;
    logic [2:0]       frm;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [4:0]       exc;
    logic [TAG_W-1:0] tag;
    logic             illegal;
`ifdef FPU_SCHED_TIMEOUT_EN
    logic             timeout;
`endif
  } rsp_t;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
  state_t state;

  // command FIFO; extra pointer bit separates full from empty
  cmd_t        cmd_mem [CMD_DEPTH];
  cmd_t        head;
  logic [CA:0] cmd_wr, cmd_rd;
  logic        cmd_empty, cmd_full, cmd_push, cmd_pop;
  logic        head_illegal, head_long;

  assign cmd_empty = (cmd_wr == cmd_rd);
  assign cmd_full  = (cmd_wr[CA] != cmd_rd[CA]) && (cmd_wr[CA-1:0] == cmd_rd[CA-1:0]);
  assign cmd_ready = !cmd_full;
  assign cmd_push  = cmd_valid && !cmd_full;
  assign cmd_pop   = (state == IDLE) && !cmd_empty;
  assign head      = cmd_mem[cmd_rd[CA-1:0]];

  assign head_illegal = (head.opsel > 4'd10) ||
                        (((head.opsel == 4'd1) || (head.opsel == 4'd2)) && (head.op == 2'd3));
  assign head_long    = (head.opsel == 4'd9) || (head.opsel == 4'd10);

  always_ff @(posedge clk)
    if (cmd_push) cmd_mem[cmd_wr[CA-1:0]] <= cmd_t'{cmd_opsel, cmd_op, cmd_frm, cmd_a, cmd_b, cmd_c, cmd_tag};

  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      cmd_wr <= '0;
      cmd_rd <= '0;
    end else begin
      if (cmd_push) cmd_wr <= cmd_wr + 1'b1;
      if (cmd_pop)  cmd_rd <= cmd_rd + 1'b1;
    end

  // result FIFO; storage is reset so the rsp_* outputs read 0 out of reset
  rsp_t        rsp_mem [RSP_DEPTH];
  rsp_t        res, rsp_head;
  logic [RA:0] rsp_wr, rsp_rd;
  logic        rsp_empty, rsp_full, rsp_push, rsp_pop;

  assign rsp_empty = (rsp_wr == rsp_rd);
  assign rsp_full  = (rsp_wr[RA] != rsp_rd[RA]) && (rsp_wr[RA-1:0] == rsp_rd[RA-1:0]);
  assign rsp_push  = (state == RESP) && !rsp_full;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rd[RA-1:0]];

  assign rsp_valid   = !rsp_empty;
  assign rsp_data    = rsp_head.data;
  assign rsp_exc     = rsp_head.exc;
  assign rsp_tag     = rsp_head.tag;
  assign rsp_illegal = rsp_head.illegal;
`ifdef FPU_SCHED_TIMEOUT_EN
  assign rsp_timeout = rsp_head.timeout;
`endif
  assign busy = (state != IDLE) || !cmd_empty || !rsp_empty;

  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      rsp_wr <= '0;
      rsp_rd <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) rsp_mem[i] <= '0;
    end else begin
      if (rsp_push) begin
        rsp_mem[rsp_wr[RA-1:0]] <= res;
        rsp_wr <= rsp_wr + 1'b1;
      end
      if (rsp_pop) rsp_rd <= rsp_rd + 1'b1;
    end

  logic [TAG_W-1:0] ex_tag;
  logic             ex_illegal, ex_long;
`ifdef FPU_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      state      <= IDLE;
      fu_valid   <= '0;
      fu_op      <= '0;
      fu_frm     <= '0;
      fu_a       <= '0;
      fu_b       <= '0;
      fu_c       <= '0;
      ex_tag     <= '0;
      ex_illegal <= 1'b0;
      ex_long    <= 1'b0;
      res        <= '0;
`ifdef FPU_SCHED_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (cmd_pop) begin
          fu_op      <= head.op;
          fu_frm     <= head.frm;
          fu_a       <= head.a;
          fu_b       <= head.b;
          fu_c       <= head.c;
          ex_tag     <= head.tag;
          ex_illegal <= head_illegal;
          ex_long    <= head_long;
          fu_valid   <= head_illegal ? 11'd0 : (11'd1 << head.opsel);
          state      <= EXEC;
        end
        EXEC: begin
          fu_valid    <= '0;
          res.tag     <= ex_tag;
          res.illegal <= ex_illegal;
`ifdef FPU_SCHED_TIMEOUT_EN
          res.timeout <= 1'b0;
          wait_cnt    <= '0;
`endif
          if (ex_illegal) begin
            res.data <= '0;
            res.exc  <= '0;
            state    <= RESP;
          end else if (ex_long) begin
            state    <= WAIT;
          end else begin
            res.data <= fu_result;
            res.exc  <= fu_exc;
            state    <= RESP;
          end
        end
        WAIT: if (fu_done) begin
          res.data <= fu_result;
          res.exc  <= fu_exc;
          state    <= RESP;
        end
`ifdef FPU_SCHED_TIMEOUT_EN
        else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          res.data    <= '0;
          res.exc     <= 5'b00001;
          res.illegal <= 1'b1;
          res.timeout <= 1'b1;
          state       <= RESP;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
`endif
        RESP: if (rsp_push) state <= IDLE;
        default: state <= IDLE;
      endcase
    end

  // a clear coinciding with a push keeps only the new flags
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l)        exc_sticky <= '0;
    else if (exc_clr)  exc_sticky <= rsp_push ? res.exc : 5'd0;
    else if (rsp_push) exc_sticky <= exc_sticky | res.exc;

endmodule

// File: tb/tb_fpu_cmd_scheduler.sv
// Bench for fpu_cmd_scheduler: directed latency/illegal/divider/backpressure/sticky/reset cases
// plus randomized traffic scored against a queue-based reference model.
`timescale 1ns/1ps
module tb_fpu_cmd_scheduler;
  localparam int W  = 32;
  localparam int TW = 4;

  logic          clk = 1'b0, rst_l = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [3:0]    cmd_opsel = '0;
  logic [1:0]    cmd_op = '0;
  logic [2:0]    cmd_frm = '0;
  logic [W-1:0]  cmd_a = '0, cmd_b = '0, cmd_c = '0;
  logic [TW-1:0] cmd_tag = '0;
  logic [10:0]   fu_valid;
  logic [1:0]    fu_op;
  logic [2:0]    fu_frm;
  logic [W-1:0]  fu_a, fu_b, fu_c, fu_result;
  logic [4:0]    fu_exc;
  logic          fu_done = 1'b0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [W-1:0]  rsp_data;
  logic [4:0]    rsp_exc;
  logic [TW-1:0] rsp_tag;
  logic          rsp_illegal;
`ifdef FPU_SCHED_TIMEOUT_EN
  logic          rsp_timeout;
`endif
  logic [4:0]    exc_sticky;
  logic          exc_clr = 1'b0;
  logic          busy;

  always #5 clk = ~clk;

  fpu_cmd_scheduler #(.WIDTH(W), .CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(TW), .TIMEOUT(64)) dut (
    .clk(clk), .rst_l(rst_l),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opsel(cmd_opsel), .cmd_op(cmd_op),
    .cmd_frm(cmd_frm), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_tag(cmd_tag),
    .fu_valid(fu_valid), .fu_op(fu_op), .fu_frm(fu_frm), .fu_a(fu_a), .fu_b(fu_b), .fu_c(fu_c),
    .fu_result(fu_result), .fu_exc(fu_exc), .fu_done(fu_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_exc(rsp_exc),
    .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal),
`ifdef FPU_SCHED_TIMEOUT_EN
    .rsp_timeout(rsp_timeout),
`endif
    .exc_sticky(exc_sticky), .exc_clr(exc_clr), .busy(busy)
  );

  typedef struct { logic [W-1:0] data; logic [4:0] exc; logic [TW-1:0] tag; logic ill; } exp_t;
  typedef struct {
    logic [10:0] oh; logic lng; logic [3:0] sel; logic [1:0] op; logic [2:0] frm;
    logic [W-1:0] a, b, c;
  } iss_t;

  exp_t         exp_q[$];
  iss_t         iss_q[$];
  int           n_cmp = 0, n_err = 0;
  logic [4:0]   sticky_exp = '0;
  bit           ovr_en = 1'b0;
  logic [W-1:0] ovr_res = '0;
  logic [4:0]   ovr_exc = '0;
  int           rdy_mode = 0;
  int           fix_lat = -1;
  bit           orphan = 1'b0;
  logic [W-1:0] done_res = '0;
  logic [4:0]   done_exc = '0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stand-in functional unit behaviour
  function automatic logic [W-1:0] fres(logic [3:0] s, logic [1:0] op, logic [2:0] frm,
                                        logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c);
    return (a ^ {b[15:0], b[31:16]}) + c + {23'd0, s, op, frm};
  endfunction

  function automatic logic [4:0] fexc(logic [W-1:0] r);
    return r[4:0] ^ r[31:27];
  endfunction

  function automatic logic [3:0] oh2i(logic [10:0] v);
    logic [3:0] r = '0;
    for (int i = 0; i < 11; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  always_comb begin
    if (fu_done) begin
      fu_result = done_res;
      fu_exc    = done_exc;
    end else if (ovr_en) begin
      fu_result = ovr_res;
      fu_exc    = ovr_exc;
    end else begin
      fu_result = fres(oh2i(fu_valid), fu_op, fu_frm, fu_a, fu_b, fu_c);
      fu_exc    = fexc(fu_result);
    end
  end

  task automatic model_accept(logic [3:0] s, logic [1:0] op, logic [2:0] frm,
                              logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, logic [TW-1:0] tag);
    exp_t e;
    iss_t i;
    e.tag = tag;
    e.ill = (s > 4'd10) || (((s == 4'd1) || (s == 4'd2)) && (op == 2'd3));
    if (e.ill) begin
      e.data = '0;
      e.exc  = '0;
    end else begin
      e.data = ovr_en ? ovr_res : fres(s, op, frm, a, b, c);
      e.exc  = ovr_en ? ovr_exc : fexc(e.data);
      i.oh = 11'd1 << s; i.lng = (s == 4'd9) || (s == 4'd10); i.sel = s;
      i.op = op; i.frm = frm; i.a = a; i.b = b; i.c = c;
      iss_q.push_back(i);
    end
    exp_q.push_back(e);
    sticky_exp |= e.exc;
  endtask

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic send(logic [3:0] s, logic [1:0] op, logic [2:0] frm,
                      logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] c, logic [TW-1:0] tag);
    int n = 0;
    cmd_valid = 1'b1; cmd_opsel = s; cmd_op = op; cmd_frm = frm;
    cmd_a = a; cmd_b = b; cmd_c = c; cmd_tag = tag;
    while (!cmd_ready && n < 400) begin @(negedge clk); n++; end
    if (cmd_ready) model_accept(s, op, frm, a, b, c, tag);
    else chk("cmd_accept_timeout", 128'(cmd_ready), 128'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < bound) begin @(negedge clk); n++; end
    if (busy || exp_q.size() != 0) chk("drain_timeout", 128'({busy, 32'(exp_q.size())}), 128'(0));
  endtask

  task automatic lat_run(logic [3:0] s, logic [W-1:0] a, logic [W-1:0] b, logic [TW-1:0] tag,
                         logic [W-1:0] res, logic [4:0] exc, bit clr);
    ovr_en = 1'b1; ovr_res = res; ovr_exc = exc;
    send(s, 2'd0, 3'd0, a, b, '0, tag);
    @(negedge clk);
    chk("lat_fu_valid", 128'(fu_valid), 128'(11'd1 << s));
    @(negedge clk);
    chk("lat_rsp_early", 128'(rsp_valid), 128'(0));
    exc_clr = clr;
    @(negedge clk);
    exc_clr = 1'b0;
    chk("lat_rsp_valid", 128'(rsp_valid), 128'(1));
    chk("lat_rsp_data", 128'(rsp_data), 128'(res));
    chk("lat_rsp_tag", 128'(rsp_tag), 128'(tag));
    wait_idle(50);
    ovr_en = 1'b0;
  endtask

  // consumer side: drives rsp_ready and scores every pop
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      if (rst_l && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_spurious", 128'(rsp_valid), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk("rsp_data", 128'(rsp_data), 128'(e.data));
          chk("rsp_exc", 128'(rsp_exc), 128'(e.exc));
          chk("rsp_tag", 128'(rsp_tag), 128'(e.tag));
          chk("rsp_illegal", 128'(rsp_illegal), 128'(e.ill));
`ifdef FPU_SCHED_TIMEOUT_EN
          chk("rsp_timeout", 128'(rsp_timeout), 128'(0));
`endif
        end
      end
    end
  end

  // functional-unit side: checks issues against the model and answers div/sqrt
  initial begin
    int   cnt;
    bit   pend;
    iss_t pe, e;
    cnt = 0; pend = 1'b0;
    forever begin
      @(negedge clk);
      fu_done = 1'b0;
      if (pend) begin
        if (rst_l && !orphan)
          chk("wait_opnd_stable", 128'({fu_a, fu_b, fu_c, fu_op, fu_frm}),
              128'({pe.a, pe.b, pe.c, pe.op, pe.frm}));
        if (cnt == 0) begin
          fu_done = 1'b1;
          pend    = 1'b0;
          orphan  = 1'b0;
        end else cnt--;
      end
      if (rst_l && fu_valid != '0) begin
        if (iss_q.size() == 0) chk("issue_spurious", 128'(fu_valid), 128'(0));
        else begin
          e = iss_q.pop_front();
          chk("issue_sel", 128'(fu_valid), 128'(e.oh));
          chk("issue_opnd", 128'({fu_a, fu_b, fu_c, fu_op, fu_frm}), 128'({e.a, e.b, e.c, e.op, e.frm}));
          if (e.lng) begin
            pend = 1'b1;
            pe   = e;
            cnt  = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 15));
            done_res = ovr_en ? ovr_res : fres(e.sel, e.op, e.frm, e.a, e.b, e.c);
            done_exc = ovr_en ? ovr_exc : fexc(done_res);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_fu_valid", 128'(fu_valid), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_rsp_data", 128'(rsp_data), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_exc_sticky", 128'(exc_sticky), 128'(0));
    rst_l = 1'b1;
    @(negedge clk);
    rdy_mode = 1;

    // single-cycle addsub: latency and data
    lat_run(4'd6, 32'h3F800000, 32'h40000000, 4'd5, 32'h40400000, 5'd0, 1'b0);

    // illegal encodings
    send(4'd2, 2'd3, 3'd0, 32'h1234, 32'h5678, 32'h0, 4'd1);
    send(4'd12, 2'd0, 3'd1, 32'hdead, 32'hbeef, 32'h0, 4'd2);
    send(4'd1, 2'd3, 3'd2, 32'h1, 32'h2, 32'h3, 4'd3);
    wait_idle(100);

    // divider with a long done latency
    ovr_en = 1'b1; ovr_res = 32'h3F000000; ovr_exc = 5'd0; fix_lat = 20;
    send(4'd9, 2'd0, 3'd0, 32'h3F800000, 32'h40000000, 32'h0, 4'd7);
    repeat (12) @(negedge clk);
    chk("div_no_early_rsp", 128'(rsp_valid), 128'(0));
    chk("div_busy", 128'(busy), 128'(1));
    wait_idle(100);
    ovr_en = 1'b0; fix_lat = -1;

    // sticky exception flags, including clear coinciding with a push
    exc_clr = 1'b1; @(negedge clk); exc_clr = 1'b0; sticky_exp = '0;
    chk("sticky_cleared", 128'(exc_sticky), 128'(0));
    lat_run(4'd3, 32'h11, 32'h22, 4'd8, 32'hA5A5A5A5, 5'b00001, 1'b0);
    lat_run(4'd4, 32'h33, 32'h44, 4'd9, 32'h5A5A5A5A, 5'b10000, 1'b0);
    chk("sticky_or", 128'(exc_sticky), 128'(5'b10001));
    lat_run(4'd5, 32'h55, 32'h66, 4'd10, 32'h0F0F0F0F, 5'b00100, 1'b1);
    chk("sticky_clr_push", 128'(exc_sticky), 128'(5'b00100));
    sticky_exp = 5'b00100;

    // backpressure: nine back-to-back commands fill both FIFOs and the exec slot
    rdy_mode = 0;
    for (int i = 0; i < 9; i++)
      send(4'($urandom_range(3, 8)), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 4'(i));
    repeat (6) @(negedge clk);
    chk("bp_cmd_ready_low", 128'(cmd_ready), 128'(0));
    chk("bp_rsp_valid", 128'(rsp_valid), 128'(1));
    rdy_mode = 1;
    wait_idle(300);

    // randomized traffic with random consumer stalls and div/sqrt latencies
    exc_clr = 1'b1; @(negedge clk); exc_clr = 1'b0; sticky_exp = '0;
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      send(4'($urandom_range(0, 15)), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom, 4'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(3000);
    chk("rand_sticky", 128'(exc_sticky), 128'(sticky_exp));
    chk("rand_issue_left", 128'(iss_q.size()), 128'(0));

    // reset while waiting on sqrt with two commands queued
    rdy_mode = 1; fix_lat = 100;
    send(4'd10, 2'd0, 3'd0, 32'h40800000, 32'h0, 32'h0, 4'd3);
    send(4'd6, 2'd1, 3'd0, 32'h1, 32'h2, 32'h3, 4'd4);
    send(4'd0, 2'd0, 3'd0, 32'h4, 32'h5, 32'h6, 4'd5);
    repeat (5) @(negedge clk);
    chk("rst_mid_busy_before", 128'(busy), 128'(1));
    rst_l = 1'b0; orphan = 1'b1;
    #1;
    chk("rst_mid_fu_valid", 128'(fu_valid), 128'(0));
    chk("rst_mid_fu_a", 128'(fu_a), 128'(0));
    chk("rst_mid_rsp_valid", 128'(rsp_valid), 128'(0));
    chk("rst_mid_cmd_ready", 128'(cmd_ready), 128'(1));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_sticky", 128'(exc_sticky), 128'(0));
    exp_q.delete(); iss_q.delete(); sticky_exp = '0;
    @(negedge clk);
    rst_l = 1'b1;
    seen = 1'b0;
    repeat (120) begin
      @(negedge clk);
      seen |= rsp_valid | busy | (|fu_valid);
    end
    chk("late_done_fired", 128'(orphan), 128'(0));
    chk("late_done_ignored", 128'(seen), 128'(0));
    fix_lat = -1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
